bpred_btb: RTL

- Parametrised branch predictor that supplies the fetch stage with a taken/not-taken prediction and a target.
- Combines a direct-mapped tagged branch target buffer (BTB) with a per-entry saturating-counter history table (BHT).
- Trained by the execute-stage branch resolution: taken flag, target and the prediction that travelled with the instruction.
- Computes the execute-stage mispredict/redirect signal and maintains saturating performance counters.

---
 rtl/bpred_btb.sv | 127 ++++++++++++
 1 files changed

// File: rtl/bpred_btb.sv
// Branch predictor: direct-mapped tagged BTB with a per-entry saturating
// direction counter. Fetch-side lookup has zero latency. Execute-side
// resolution trains the table, flags mispredicts and counts events.
//
// Ports:
//   clk, reset_n                 clock (rising edge), async active-low reset
//   if_pc                        fetch PC to look up
//   pred_taken, pred_target      combinational prediction for if_pc
//   ex_valid, ex_pc, ex_is_*     execute-stage instruction and its kind
//   ex_taken, ex_target          resolved direction and next PC
//   ex_pred_taken/_target        prediction carried with the instruction
//   flush_all                    invalidate every entry on the next edge
//   mispredict                   combinational redirect request at execute
//   branch_cnt, mispred_cnt      saturating performance counters
module bpred_btb #(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CNT_BITS  = 2,
  parameter int unsigned PERF_BITS = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          if_pc,
  output logic                 pred_taken,
  output logic [31:0]          pred_target,
  input  logic                 ex_valid,
  input  logic [31:0]          ex_pc,
  input  logic                 ex_is_branch,
  input  logic                 ex_is_jump,
  input  logic                 ex_is_jumpr,
  input  logic                 ex_taken,
  input  logic [31:0]          ex_target,
  input  logic                 ex_pred_taken,
  input  logic [31:0]          ex_pred_target,
  input  logic                 flush_all,
  output logic                 mispredict,
  output logic [PERF_BITS-1:0] branch_cnt,
  output logic [PERF_BITS-1:0] mispred_cnt
);

  localparam int unsigned IDX   = $clog2(ENTRIES);
  localparam int unsigned TAG_W = 30 - IDX;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
  localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);
  localparam logic [PERF_BITS-1:0] PERF_MAX = '1;

  logic                valid_q  [ENTRIES];
  logic [TAG_W-1:0]    tag_q    [ENTRIES];
  logic [31:0]         target_q [ENTRIES];
  logic                uncond_q [ENTRIES];
  logic [CNT_BITS-1:0] cnt_q    [ENTRIES];

  logic [IDX-1:0]   if_idx;
  logic [TAG_W-1:0] if_tag;
  logic             if_hit;
  logic [IDX-1:0]   ex_idx;
  logic [TAG_W-1:0] ex_tag;
  logic             ex_hit;
  logic             res;
  logic             ex_uncond;
  logic             unused_pc_lsbs;

  // pc[1:0] carry no information for 4-byte aligned instructions
  assign unused_pc_lsbs = ^{if_pc[1:0], ex_pc[1:0]};

  // Fetch lookup: reads pre-update contents, no bypass from execute
  assign if_idx      = if_pc[IDX+1:2];
  assign if_tag      = if_pc[31:IDX+2];
  assign if_hit      = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign pred_taken  = if_hit && (uncond_q[if_idx] || cnt_q[if_idx][CNT_BITS-1]);
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  // Execute resolution
  assign ex_idx     = ex_pc[IDX+1:2];
  assign ex_tag     = ex_pc[31:IDX+2];
  assign ex_hit     = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);
  assign res        = ex_valid && (ex_is_branch || ex_is_jump || ex_is_jumpr);
  assign ex_uncond  = ex_is_jumpr || ex_is_jump;
  assign mispredict = res && ((ex_taken != ex_pred_taken) ||
                              (ex_taken && (ex_target != ex_pred_target)));

  // Valid bits and direction counters; flush wins over a same-cycle update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_WNT;
      end
    end else if (flush_all) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (res) begin
      if (ex_hit) begin
        if (ex_taken) begin
          if (cnt_q[ex_idx] != CNT_MAX) cnt_q[ex_idx] <= cnt_q[ex_idx] + CNT_BITS'(1);
        end else begin
          if (cnt_q[ex_idx] != '0) cnt_q[ex_idx] <= cnt_q[ex_idx] - CNT_BITS'(1);
        end
      end else if (ex_taken) begin
        valid_q[ex_idx] <= 1'b1;
        cnt_q[ex_idx]   <= CNT_WT;
      end
    end
  end

  // Entry payload: only meaningful while valid, so it carries no reset
  always_ff @(posedge clk) begin
    if (res && ex_taken && !flush_all) begin
      tag_q[ex_idx]    <= ex_tag;
      target_q[ex_idx] <= ex_target;
      uncond_q[ex_idx] <= ex_uncond;
    end
  end

  // Saturating performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (res && (branch_cnt != PERF_MAX)) branch_cnt <= branch_cnt + PERF_BITS'(1);
      if (mispredict && (mispred_cnt != PERF_MAX)) mispred_cnt <= mispred_cnt + PERF_BITS'(1);
    end
  end

endmodule
